// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the requester handshakes, the FIFO write port and the grant status
// of fifo_wr_arbiter.
//   req_valid_i / req_ready_o / req_data_i / req_last_i : N requester beats
//   fifo_wvalid_o / fifo_wready_i / fifo_wdata_o        : FIFO write port
//   gnt_o / gnt_idx_o / busy_o                          : current grant status
// The slave modport is the arbiter. The master modport is its environment,
// meaning the requesters together with the FIFO.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
  parameter int N     = 4,
  parameter int Width = 16
);
  localparam int IdxW = $clog2(N);

  logic [N-1:0]       req_valid_i;
  logic [N-1:0]       req_ready_o;
  logic [N*Width-1:0] req_data_i;
  logic [N-1:0]       req_last_i;
  logic               fifo_wvalid_o;
  logic               fifo_wready_i;
  logic [Width-1:0]   fifo_wdata_o;
  logic [N-1:0]       gnt_o;
  logic [IdxW-1:0]    gnt_idx_o;
  logic               busy_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, fifo_wready_i,
    output req_ready_o, fifo_wvalid_o, fifo_wdata_o, gnt_o, gnt_idx_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, fifo_wready_i,
    input  req_ready_o, fifo_wvalid_o, fifo_wdata_o, gnt_o, gnt_idx_o, busy_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one synchronous FIFO write port between
// N valid/ready requesters. A grant is held for up to MaxBurst accepted beats,
// or until the owner flags its last beat. The grant also stays put while the
// FIFO back-pressures. The request-to-FIFO path is combinational.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   clr_i  : synchronous flush of the arbitration state
//   bus    : fifo_wr_arbiter_if.slave, which carries the requester, FIFO and
//            grant signals
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int N        = 4,
  parameter int Width    = 16,
  parameter int MaxBurst = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IdxW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [IdxW-1:0] prio, prio_nxt;
  logic [IdxW-1:0] owner, owner_nxt;
  logic [7:0]      beats, beats_nxt;

  logic             win_vld;
  logic [IdxW-1:0]  win;
  logic [IdxW:0]    scan;
  logic [Width-1:0] sel_data;
  logic             sel_valid, sel_last;
  logic [N-1:0]     win_onehot;
  logic             fwd, acc, rel;

  // Wraps at N-1 so that a non-power-of-two N never reaches an unused index.
  function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + IdxW'(1);
  endfunction

  // Winner: the owner while locked, otherwise the first valid requester
  // found when scanning upward from prio. The scan runs from the farthest
  // offset down to the nearest, so the nearest valid requester is assigned
  // last and wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    scan    = '0;
    if (state == LOCKED) begin
      win_vld = 1'b1;
      win     = owner;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        scan = {1'b0, prio} + (IdxW + 1)'(i);
        if (scan >= (IdxW + 1)'(N)) scan = scan - (IdxW + 1)'(N);
        if (bus.req_valid_i[scan[IdxW-1:0]]) begin
          win_vld = 1'b1;
          win     = scan[IdxW-1:0];
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (win == IdxW'(k)) sel_data = bus.req_data_i[k*Width +: Width];
    end
  end

  assign sel_valid  = win_vld & bus.req_valid_i[win];
  assign sel_last   = bus.req_last_i[win];
  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win;

  // A flush or a reset in progress blocks forwarding, so no beat is taken
  // on either.
  assign fwd = sel_valid & ~clr_i & ~rst_i;
  assign acc = fwd & bus.fifo_wready_i;
  assign rel = acc & (sel_last | (({1'b0, beats} + 9'd1) == 9'(MaxBurst)));

  assign bus.fifo_wvalid_o = fwd;
  assign bus.fifo_wdata_o  = fwd ? sel_data : '0;
  assign bus.req_ready_o   = acc ? win_onehot : '0;
  assign bus.gnt_o         = (win_vld & ~rst_i) ? win_onehot : '0;
  assign bus.gnt_idx_o     = (win_vld & ~rst_i) ? win : '0;
  assign bus.busy_o        = (state == LOCKED) & ~rst_i;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    owner_nxt = owner;
    beats_nxt = beats;
    if (clr_i) begin
      state_nxt = IDLE;
      prio_nxt  = '0;
      owner_nxt = '0;
      beats_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            if (rel) begin
              prio_nxt  = idx_inc(win);
              beats_nxt = '0;
            end else begin
              // A stalled first beat also locks, so the grant cannot move
              // while the beat is waiting on the FIFO.
              state_nxt = LOCKED;
              owner_nxt = win;
              beats_nxt = acc ? 8'd1 : 8'd0;
            end
          end
        end
        LOCKED: begin
          if (rel) begin
            state_nxt = IDLE;
            prio_nxt  = idx_inc(owner);
            beats_nxt = '0;
          end else if (acc) begin
            beats_nxt = beats + 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      prio  <= '0;
      owner <= '0;
      beats <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      owner <= owner_nxt;
      beats <= beats_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  logic clk;
  logic rst;
  logic clr4;
  logic clr3;
  int   total;
  int   bad;

  fifo_wr_arbiter_if #(.N(4), .Width(16)) if4 ();
  fifo_wr_arbiter_if #(.N(3), .Width(8))  if3 ();

  fifo_wr_arbiter #(.N(4), .Width(16), .MaxBurst(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr4), .bus(if4.slave)
  );

  fifo_wr_arbiter #(.N(3), .Width(8), .MaxBurst(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr3), .bus(if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clr4  = 1'b0;
    clr3  = 1'b0;
    if4.req_valid_i   = 4'hF;
    if4.req_last_i    = 4'h0;
    if4.req_data_i    = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    if4.fifo_wready_i = 1'b1;
    if3.req_valid_i   = 3'b000;
    if3.req_last_i    = 3'b000;
    if3.req_data_i    = '0;
    if3.fifo_wready_i = 1'b0;

    // Outputs are held at zero under reset even with every request pending.
    #2;
    chk("rst_wvalid", if4.fifo_wvalid_o, 0);
    chk("rst_ready",  if4.req_ready_o, 0);
    chk("rst_gnt",    if4.gnt_o, 0);
    chk("rst_idx",    if4.gnt_idx_o, 0);
    chk("rst_busy",   if4.busy_o, 0);
    chk("rst_wdata",  if4.fifo_wdata_o, 0);

    // All requesters valid, each beat a last beat: plain rotation.
    @(negedge clk);
    rst = 1'b0;
    if4.req_last_i = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_idx",   if4.gnt_idx_o, c % 4);
      chk("rr_gnt",   if4.gnt_o, 1 << (c % 4));
      chk("rr_ready", if4.req_ready_o, 1 << (c % 4));
      chk("rr_wdata", if4.fifo_wdata_o, 16'hA000 + (c % 4));
      chk("rr_busy",  if4.busy_o, 0);
      @(negedge clk);
    end
    if4.req_valid_i = 4'h0;
    #1;
    chk("idle_gnt",    if4.gnt_o, 0);
    chk("idle_idx",    if4.gnt_idx_o, 0);
    chk("idle_wvalid", if4.fifo_wvalid_o, 0);
    @(negedge clk);

    // Requester 2 sends 6 beats. The burst is cut after beat 4, and 2 then
    // wins again for beats 5 and 6.
    if4.req_valid_i = 4'b0100;
    for (int b = 1; b <= 6; b++) begin
      if4.req_data_i[2*16 +: 16] = 16'h2000 + 16'(b);
      if4.req_last_i = (b == 6) ? 4'b0100 : 4'b0000;
      #1;
      chk("burst_idx",   if4.gnt_idx_o, 2);
      chk("burst_ready", if4.req_ready_o, 4'b0100);
      chk("burst_wdata", if4.fifo_wdata_o, 16'h2000 + b);
      chk("burst_busy",  if4.busy_o, (b == 2 || b == 3 || b == 4 || b == 6) ? 1 : 0);
      @(negedge clk);
    end
    if4.req_valid_i = 4'h0;
    @(negedge clk);

    // Lock on requester 0 for 2 beats, then flush.
    if4.req_valid_i = 4'b0001;
    if4.req_last_i  = 4'b0000;
    if4.req_data_i[0 +: 16] = 16'h0B01;
    #1;
    chk("clr_idx0",  if4.gnt_idx_o, 0);
    chk("clr_busy0", if4.busy_o, 0);
    @(negedge clk);
    if4.req_data_i[0 +: 16] = 16'h0B02;
    #1;
    chk("clr_busy1", if4.busy_o, 1);
    chk("clr_rdy1",  if4.req_ready_o, 4'b0001);
    @(negedge clk);
    clr4 = 1'b1;
    if4.req_data_i[0 +: 16] = 16'h0B03;
    #1;
    chk("clr_wvalid", if4.fifo_wvalid_o, 0);
    chk("clr_ready",  if4.req_ready_o, 0);
    chk("clr_wdata",  if4.fifo_wdata_o, 0);
    @(negedge clk);
    clr4 = 1'b0;
    if4.req_valid_i = 4'b0000;
    #1;
    chk("clr_after_busy", if4.busy_o, 0);
    chk("clr_after_gnt",  if4.gnt_o, 0);
    @(negedge clk);

    // Requesters 1 and 3 with the FIFO stalled for 3 cycles. After the flush
    // prio is 0, so requester 1 wins.
    if4.req_valid_i = 4'b1010;
    if4.req_last_i  = 4'b1010;
    if4.req_data_i[1*16 +: 16] = 16'h1111;
    if4.req_data_i[3*16 +: 16] = 16'h3333;
    if4.fifo_wready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_idx",   if4.gnt_idx_o, 1);
      chk("stall_wdata", if4.fifo_wdata_o, 16'h1111);
      chk("stall_ready", if4.req_ready_o, 0);
      chk("stall_busy",  if4.busy_o, (s > 0) ? 1 : 0);
      @(negedge clk);
    end
    if4.fifo_wready_i = 1'b1;
    #1;
    chk("unstall_ready", if4.req_ready_o, 4'b0010);
    chk("unstall_idx",   if4.gnt_idx_o, 1);
    @(negedge clk);
    if4.req_valid_i = 4'b1000;
    #1;
    chk("next3_idx",   if4.gnt_idx_o, 3);
    chk("next3_busy",  if4.busy_o, 0);
    chk("next3_ready", if4.req_ready_o, 4'b1000);
    chk("next3_wdata", if4.fifo_wdata_o, 16'h3333);
    @(negedge clk);
    if4.req_valid_i = 4'b0000;
    @(negedge clk);

    // Asynchronous reset in the middle of a burst on requester 0.
    if4.req_valid_i = 4'b0001;
    if4.req_last_i  = 4'b0000;
    if4.req_data_i[0 +: 16] = 16'h0C01;
    #1;
    chk("arst_idx0", if4.gnt_idx_o, 0);
    @(negedge clk);
    if4.req_data_i[0 +: 16] = 16'h0C02;
    #1;
    chk("arst_busy_pre", if4.busy_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wvalid", if4.fifo_wvalid_o, 0);
    chk("arst_ready",  if4.req_ready_o, 0);
    chk("arst_gnt",    if4.gnt_o, 0);
    chk("arst_busy",   if4.busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    if4.req_valid_i = 4'b1000;
    if4.req_last_i  = 4'b1001;
    if4.req_data_i[3*16 +: 16] = 16'h3C03;
    #1;
    chk("post_rst_idx3", if4.gnt_idx_o, 3);
    #1;
    if4.req_valid_i = 4'b1001;
    #1;
    chk("post_rst_idx0",   if4.gnt_idx_o, 0);
    chk("post_rst_wdata0", if4.fifo_wdata_o, 16'h0C02);
    chk("post_rst_ready0", if4.req_ready_o, 4'b0001);
    @(negedge clk);
    if4.req_valid_i = 4'b1000;
    #1;
    chk("post_rst_idx3b", if4.gnt_idx_o, 3);
    chk("post_rst_wdata3", if4.fifo_wdata_o, 16'h3C03);
    @(negedge clk);
    if4.req_valid_i = 4'b0000;

    // N=3: prio wraps from 2 back to 0.
    if3.req_valid_i   = 3'b100;
    if3.req_last_i    = 3'b111;
    if3.req_data_i    = {8'h22, 8'h11, 8'h55};
    if3.fifo_wready_i = 1'b1;
    #1;
    chk("n3_idx2",   if3.gnt_idx_o, 2);
    chk("n3_wdata2", if3.fifo_wdata_o, 8'h22);
    chk("n3_ready2", if3.req_ready_o, 3'b100);
    @(negedge clk);
    if3.req_valid_i = 3'b101;
    #1;
    chk("n3_idx0",   if3.gnt_idx_o, 0);
    chk("n3_gnt0",   if3.gnt_o, 3'b001);
    chk("n3_wdata0", if3.fifo_wdata_o, 8'h55);
    @(negedge clk);
    if3.req_valid_i = 3'b000;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
